// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Registers the EX bus under the stall vector, aligns/extends load data from
// the synchronous data SRAM and presents the WB bus plus the ID forwarding bus.
// Optional build macro MEM_RDATA_HOLD_EN: holds the SRAM read data of a load
// while WB is stalled so the result is independent of the live read port.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 151,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_RF_WD = 104,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
    logic                    first_cycle;

    logic        bubble;
    logic        advance;

    logic [7:0]  mem_op;
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        ram_en;
    logic        ram_wen;
    logic [3:0]  ram_sel;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    logic        op_lb, op_lbu, op_lh, op_lhu, op_lw;
    logic [31:0] rdata_eff;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    // Bits of the stall vector and store opcodes that this stage does not consume.
    logic        unused_bits;

    assign bubble  = stall[3] & ~stall[4];
    assign advance = ~stall[3];

    // Input pipeline register: reset, bubble, capture or hold.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ex_to_mem_bus_r <= '0;
        end else if (advance) begin
            ex_to_mem_bus_r <= ex_to_mem_bus;
        end
    end

    // Marks the first cycle an instruction spends in MEM.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            first_cycle <= 1'b0;
        end else begin
            first_cycle <= advance;
        end
    end

    assign mem_op     = ex_to_mem_bus_r[150:143];
    assign hilo_bus   = ex_to_mem_bus_r[142:77];
    assign pc         = ex_to_mem_bus_r[76:45];
    assign ram_en     = ex_to_mem_bus_r[44];
    assign ram_wen    = ex_to_mem_bus_r[43];
    assign ram_sel    = ex_to_mem_bus_r[42:39];
    assign sel_rf_res = ex_to_mem_bus_r[38];
    assign rf_we      = ex_to_mem_bus_r[37];
    assign rf_waddr   = ex_to_mem_bus_r[36:32];
    assign ex_result  = ex_to_mem_bus_r[31:0];

    assign op_lb  = mem_op[7];
    assign op_lbu = mem_op[6];
    assign op_lh  = mem_op[5];
    assign op_lhu = mem_op[4];
    assign op_lw  = mem_op[3];

`ifdef MEM_RDATA_HOLD_EN
    logic        hold_valid;
    logic [31:0] hold_data;
    logic        is_load;

    assign is_load = op_lb | op_lbu | op_lh | op_lhu | op_lw;

    // Latch the read data of a load entering a WB stall; released when WB moves.
    always_ff @(posedge clk) begin
        if (rst || bubble || !stall[4]) begin
            hold_valid <= 1'b0;
        end else if (first_cycle && is_load && stall[4]) begin
            hold_valid <= 1'b1;
            hold_data  <= data_sram_rdata;
        end
    end

    assign rdata_eff = hold_valid ? hold_data : data_sram_rdata;
`else
    assign rdata_eff = data_sram_rdata;
`endif

    // Load alignment and sign/zero extension.
    always_comb begin
        load_byte = '0;
        case (ram_sel)
            4'b0001: load_byte = rdata_eff[7:0];
            4'b0010: load_byte = rdata_eff[15:8];
            4'b0100: load_byte = rdata_eff[23:16];
            4'b1000: load_byte = rdata_eff[31:24];
            default: load_byte = '0;
        endcase
        load_half = ram_sel[0] ? rdata_eff[15:0] : rdata_eff[31:16];
        load_data = rdata_eff;
        if (op_lb) begin
            load_data = {{24{load_byte[7]}}, load_byte};
        end else if (op_lbu) begin
            load_data = {24'h0, load_byte};
        end else if (op_lh) begin
            load_data = {{16{load_half[15]}}, load_half};
        end else if (op_lhu) begin
            load_data = {16'h0, load_half};
        end
    end

    assign rf_wdata = (sel_rf_res & ram_en & ~ram_wen) ? load_data : ex_result;

    assign mem_to_wb_bus = {hilo_bus, pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {hilo_bus, rf_we, rf_waddr, rf_wdata};

    assign unused_bits = ^{stall[5], stall[2:0], mem_op[2:0], op_lw, first_cycle};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// field-level reference model. Honors MEM_RDATA_HOLD_EN like the design.
module tb_mem_stage;

    localparam int EX_W = 151;
    localparam int WB_W = 136;
    localparam int RF_W = 104;
    localparam int ST_W = 6;

`ifdef MEM_RDATA_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [ST_W-1:0] stall;
    logic [EX_W-1:0] ex_to_mem_bus;
    logic [31:0]     data_sram_rdata;
    logic [WB_W-1:0] mem_to_wb_bus;
    logic [RF_W-1:0] mem_to_rf_bus;

    mem_stage #(
        .EX_TO_MEM_WD(EX_W),
        .MEM_TO_WB_WD(WB_W),
        .MEM_TO_RF_WD(RF_W),
        .STALL_WD(ST_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .ex_to_mem_bus(ex_to_mem_bus),
        .data_sram_rdata(data_sram_rdata),
        .mem_to_wb_bus(mem_to_wb_bus),
        .mem_to_rf_bus(mem_to_rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state: instruction sitting in MEM and load-hold bookkeeping.
    logic [EX_W-1:0] m_bus;
    logic            m_fresh;
    logic            m_hold_v;
    logic [31:0]     m_hold_d;
    bit              model_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [EX_W-1:0] mk_bus(input logic [7:0] op, input logic [65:0] hilo,
                                               input logic [31:0] pc, input logic en, input logic wen,
                                               input logic [3:0] sel, input logic selrf, input logic we,
                                               input logic [4:0] waddr, input logic [31:0] exres);
        return {op, hilo, pc, en, wen, sel, selrf, we, waddr, exres};
    endfunction

    function automatic logic [65:0] rand_hilo();
        logic [65:0] h;
        h = {2'($urandom), $urandom, $urandom};
        return h;
    endfunction

    // Random instruction: loads, stores or plain ALU results.
    function automatic logic [EX_W-1:0] rand_bus();
        int unsigned kind;
        logic [7:0] op;
        logic [3:0] sel;
        logic en, wen, selrf;
        kind = $urandom_range(0, 9);
        sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        if (kind <= 4) begin
            op = 8'(8'h80 >> kind);
            en = 1'b1; wen = 1'b0; selrf = 1'b1;
        end else if (kind <= 7) begin
            op = 8'(8'h04 >> (kind - 5));
            en = 1'b1; wen = 1'b1; selrf = 1'($urandom);
        end else begin
            op = 8'h00;
            en = 1'b0; wen = 1'($urandom); selrf = 1'($urandom);
        end
        return mk_bus(op, rand_hilo(), $urandom, en, wen, sel, selrf, 1'($urandom),
                      5'($urandom), $urandom);
    endfunction

    // Value a load/ALU instruction writes back, from the instruction semantics.
    function automatic logic [31:0] ref_wdata(input logic [EX_W-1:0] b, input logic [31:0] d);
        logic [7:0]  op;
        logic [3:0]  sel;
        logic [7:0]  bv;
        logic [15:0] hv;
        logic signed [31:0] sx;
        int idx;
        op  = b[150:143];
        sel = b[42:39];
        if (!(b[38] && b[44] && !b[43])) return b[31:0];
        if (op[7] || op[6]) begin
            if ($countones(sel) != 1) return 32'h0;
            idx = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            bv = 8'((d >> (8 * idx)) & 32'hFF);
            if (op[7]) begin
                sx = $signed(bv);
                return sx;
            end
            return {24'h0, bv};
        end
        if (op[5] || op[4]) begin
            hv = sel[0] ? 16'(d & 32'hFFFF) : 16'(d >> 16);
            if (op[5]) begin
                sx = $signed(hv);
                return sx;
            end
            return {16'h0, hv};
        end
        return d;
    endfunction

    task automatic compare_model();
        logic [31:0] d_eff, wd;
        logic [135:0] exp_wb, exp_rf;
        d_eff  = (HOLD_EN && m_hold_v) ? m_hold_d : data_sram_rdata;
        wd     = ref_wdata(m_bus, d_eff);
        exp_wb = {m_bus[142:77], m_bus[76:45], m_bus[37], m_bus[36:32], wd};
        exp_rf = {32'h0, m_bus[142:77], m_bus[37], m_bus[36:32], wd};
        check_eq("wb_bus", mem_to_wb_bus, exp_wb);
        check_eq("rf_bus", {32'h0, mem_to_rf_bus}, exp_rf);
    endtask

    // Apply inputs for this cycle and compare outputs before the next edge.
    task automatic drive(input logic r, input logic [5:0] s, input logic [EX_W-1:0] b,
                         input logic [31:0] d);
        rst             = r;
        stall           = s;
        ex_to_mem_bus   = b;
        data_sram_rdata = d;
        #1;
        if (model_valid) compare_model();
    endtask

    // Advance one clock and update the model from the inputs that were applied.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_bus = '0; m_fresh = 1'b0; m_hold_v = 1'b0; model_valid = 1'b1;
        end else begin
            if (!stall[4]) begin
                m_hold_v = 1'b0;
            end else if (m_fresh && (|m_bus[150:146])) begin
                m_hold_v = 1'b1;
                m_hold_d = data_sram_rdata;
            end
            if (stall[3] && !stall[4]) begin
                m_bus = '0; m_fresh = 1'b0;
            end else if (!stall[3]) begin
                m_bus = ex_to_mem_bus; m_fresh = 1'b1;
            end else begin
                m_fresh = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [5:0] rand_stall();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k <= 4) return 6'b000000;
        if (k == 5) return 6'b000111;
        if (k == 6) return 6'b001111;
        if (k <= 8) return 6'b011111;
        return 6'b111111;
    endfunction

    initial begin
        logic [EX_W-1:0] lb_bus, lhu_bus, lw_bus, sw_bus, lw2_bus;
        lb_bus  = mk_bus(8'h80, rand_hilo(), 32'hBFC0_0100, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 5'd7,  32'h0000_1003);
        lhu_bus = mk_bus(8'h10, rand_hilo(), 32'hBFC0_0104, 1'b1, 1'b0, 4'b1100, 1'b1, 1'b1, 5'd8,  32'h0000_2002);
        lw_bus  = mk_bus(8'h08, rand_hilo(), 32'hBFC0_0108, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 5'd9,  32'h0000_3000);
        sw_bus  = mk_bus(8'h01, rand_hilo(), 32'hBFC0_010C, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0,  32'h0000_0040);
        lw2_bus = mk_bus(8'h08, rand_hilo(), 32'hBFC0_0110, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 5'd10, 32'h0000_4000);

        // Reset for two cycles.
        drive(1'b1, 6'b000000, rand_bus(), $urandom); tick();
        drive(1'b1, 6'b000000, rand_bus(), $urandom); tick();
        drive(1'b0, 6'b111111, lb_bus, 32'h0);
        check_eq("rst_wb", mem_to_wb_bus, 136'h0);
        check_eq("rst_rf", {32'h0, mem_to_rf_bus}, 136'h0);
        tick();

        // lb of the top byte, sign-extended.
        drive(1'b0, 6'b000000, lb_bus, 32'h0); tick();
        drive(1'b0, 6'b000000, lhu_bus, 32'h80FF_1234);
        check_eq("lb_wdata", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'hFFFF_FF80});
        check_eq("lb_we", {135'h0, mem_to_wb_bus[37]}, 136'h1);
        tick();

        // lhu of the upper half, then a bubble at the next edge.
        drive(1'b0, 6'b001111, lw_bus, 32'hBEEF_0001);
        check_eq("lhu_wdata", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'h0000_BEEF});
        tick();
        drive(1'b0, 6'b000000, lw_bus, 32'h0);
        check_eq("bubble_wb", mem_to_wb_bus, 136'h0);
        check_eq("bubble_rf", {32'h0, mem_to_rf_bus}, 136'h0);
        tick();

        // lw held in MEM for three stalled cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'b011111, sw_bus, 32'hCAFE_F00D);
            check_eq("hold_wdata", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'hCAFE_F00D});
            check_eq("hold_pc", {104'h0, mem_to_wb_bus[69:38]}, {104'h0, 32'hBFC0_0108});
            tick();
        end
        drive(1'b0, 6'b000000, sw_bus, 32'hCAFE_F00D); tick();
        drive(1'b0, 6'b000000, lw2_bus, 32'h5555_AAAA);
        check_eq("sw_wdata", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'h0000_0040});
        check_eq("sw_we", {135'h0, mem_to_wb_bus[37]}, 136'h0);
        tick();

        // Read port changes while WB is stalled on a load.
        drive(1'b0, 6'b011111, 151'h0, 32'h1111_1111);
        check_eq("rdhold_first", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'h1111_1111});
        tick();
        drive(1'b0, 6'b011111, 151'h0, 32'h2222_2222);
        check_eq("rdhold_later", {104'h0, mem_to_wb_bus[31:0]},
                 {104'h0, (HOLD_EN ? 32'h1111_1111 : 32'h2222_2222)});
        tick();

        // Reset arriving while a load is in MEM.
        drive(1'b0, 6'b000000, lw_bus, 32'h0); tick();
        drive(1'b1, 6'b000000, lb_bus, 32'h7777_7777); tick();
        drive(1'b0, 6'b111111, lb_bus, 32'h7777_7777);
        check_eq("rst_midload", mem_to_wb_bus, 136'h0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), rand_stall(), rand_bus(), $urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
